// File: rtl/rsa_pkg.sv
// Shared widths, FSM state encoding and multiplier timing for the RSA encryptor.
package rsa_pkg;

  localparam int MW            = 16;
  localparam int EW            = 8;
  localparam int MODMUL_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: r = a*b mod n, one bit of b per cycle, MSB first.
module rsa_modmul #(
  parameter int MW = rsa_pkg::MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  input  logic [MW-1:0] n,
  output logic          done,
  output logic [MW-1:0] r
);

  localparam int CW = $clog2(MW);
  localparam int RW = MW + 2;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [RW-1:0] r_reg, r_next;
  logic [RW-1:0] n_ext, a_ext, base, dbl, dbl_red, sum, sum_red;
  logic          bit_sel;

  // While go is held the unit runs back-to-back operations; cnt==0 marks the first bit of each.
  always_comb begin
    n_ext   = {2'b00, n};
    a_ext   = {2'b00, a};
    base    = (cnt_reg == '0) ? '0 : r_reg;
    bit_sel = b[CW'(MW-1) - cnt_reg];
    dbl     = {base[RW-2:0], 1'b0};
    dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
    sum     = bit_sel ? dbl_red + a_ext : dbl_red;
    sum_red = (sum >= n_ext) ? sum - n_ext : sum;
  end

  assign done = go && (cnt_reg == CW'(MW-1));
  assign r    = sum_red[MW-1:0];

  always_comb begin
    cnt_next = cnt_reg;
    r_next   = r_reg;
    if (go) begin
      cnt_next = done ? '0 : cnt_reg + 1'b1;
      r_next   = sum_red;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      r_reg   <= '0;
    end else begin
      cnt_reg <= cnt_next;
      r_reg   <= r_next;
    end
  end

endmodule

// File: rtl/rsa_encrypt.sv
// RSA encryption c = m^e mod n by left-to-right square-and-multiply over all EW exponent bits.
module rsa_encrypt #(
  parameter int MW = rsa_pkg::MW,
  parameter int EW = rsa_pkg::EW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [MW-1:0] m,
  input  logic [EW-1:0] e,
  input  logic [MW-1:0] n,
  output logic [MW-1:0] c,
  output logic          finish
);

  import rsa_pkg::*;

  localparam int BW = $clog2(EW);

  state_t        state_reg, state_next;
  logic [MW-1:0] acc_reg, acc_next;
  logic [MW-1:0] m_reg, m_next;
  logic [EW-1:0] e_reg, e_next;
  logic [MW-1:0] n_reg, n_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [MW-1:0] c_reg, c_next;
  logic          finish_reg, finish_next;

  logic          mm_go, mm_done;
  logic [MW-1:0] mm_b, mm_r;

  assign mm_go = (state_reg != IDLE);
  assign mm_b  = (state_reg == MUL) ? m_reg : acc_reg;

  rsa_modmul #(.MW(MW)) u_modmul (
    .clk  (clk),
    .rst  (rst_n),
    .go   (mm_go),
    .a    (acc_reg),
    .b    (mm_b),
    .n    (n_reg),
    .done (mm_done),
    .r    (mm_r)
  );

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    m_next      = m_reg;
    e_next      = e_reg;
    n_next      = n_reg;
    bit_next    = bit_reg;
    c_next      = c_reg;
    finish_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          m_next = m;
          e_next = e;
          n_next = n;
          // Degenerate modulus or out-of-range message: answer 0 immediately.
          if ((n < MW'(2)) || (m >= n)) begin
            c_next      = '0;
            finish_next = 1'b1;
          end else begin
            acc_next   = MW'(1);
            bit_next   = BW'(EW-1);
            state_next = SQR;
          end
        end
      end
      SQR: begin
        if (mm_done) begin
          acc_next = mm_r;
          if (e_reg[bit_reg]) begin
            state_next = MUL;
          end else if (bit_reg == '0) begin
            c_next      = mm_r;
            finish_next = 1'b1;
            state_next  = IDLE;
          end else begin
            bit_next = bit_reg - 1'b1;
          end
        end
      end
      MUL: begin
        if (mm_done) begin
          acc_next = mm_r;
          if (bit_reg == '0) begin
            c_next      = mm_r;
            finish_next = 1'b1;
            state_next  = IDLE;
          end else begin
            bit_next   = bit_reg - 1'b1;
            state_next = SQR;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      m_reg      <= '0;
      e_reg      <= '0;
      n_reg      <= '0;
      bit_reg    <= '0;
      c_reg      <= '0;
      finish_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      m_reg      <= m_next;
      e_reg      <= e_next;
      n_reg      <= n_next;
      bit_reg    <= bit_next;
      c_reg      <= c_next;
      finish_reg <= finish_next;
    end
  end

  assign c      = c_reg;
  assign finish = finish_reg;

endmodule

// File: tb/tb_rsa_encrypt.sv
// Directed vector bench for rsa_encrypt: result, latency, pulse width, ignore-start and reset abort.
module tb_rsa_encrypt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] m;
  logic [7:0]  e;
  logic [15:0] n;
  logic [15:0] c;
  logic        finish;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rsa_encrypt dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .m      (m),
    .e      (e),
    .n      (n),
    .c      (c),
    .finish (finish)
  );

  typedef struct {
    logic [15:0] m;
    logic [7:0]  e;
    logic [15:0] n;
    int          exp_c;
    int          exp_l;
    bit          use_model;
  } vec_t;

  vec_t vecs[14];

  function automatic longint modexp(longint mm, logic [7:0] ee, longint nn);
    longint acc;
    acc = 1;
    for (int i = 7; i >= 0; i--) begin
      acc = (acc * acc) % nn;
      if (ee[i]) acc = (acc * mm) % nn;
    end
    return acc;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Issue one request, optionally pulse start again at cycle glitch, then check c, latency and pulse width.
  task automatic run(input logic [15:0] mi, input logic [7:0] ei, input logic [15:0] ni,
                     input int exp_c, input int exp_l, input int glitch, input string name);
    int cyc;
    logic [15:0] c_done;
    @(negedge clk);
    start = 1'b1; m = mi; e = ei; n = ni;
    @(posedge clk); #1;
    start = 1'b0; m = 16'hFFFF; e = 8'hA5; n = 16'h0003;
    cyc = 0;
    while (!finish && cyc < 400) begin
      if (cyc == glitch) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    c_done = c;
    $display("vec %s m=%0d e=%0d n=%0d c=%0d latency=%0d", name, mi, ei, ni, c_done, cyc);
    chk({name, "_lat"}, cyc, exp_l);
    chk({name, "_c"}, c_done, exp_c);
    @(posedge clk); #1;
    chk({name, "_pulse"}, finish, 0);
    chk({name, "_hold"}, c, c_done);
  endtask

  initial begin
    int cyc;
    int pulses;
    vecs[0]  = '{16'd89,    8'd3,   16'd3127,  1394,  160, 1'b0};
    vecs[1]  = '{16'd65,    8'd17,  16'd3233,  2790,  160, 1'b0};
    vecs[2]  = '{16'd2,     8'd10,  16'd1000,  24,    160, 1'b0};
    vecs[3]  = '{16'd5,     8'd0,   16'd3127,  1,     128, 1'b0};
    vecs[4]  = '{16'd89,    8'd1,   16'd3127,  89,    144, 1'b0};
    vecs[5]  = '{16'd1234,  8'd255, 16'd3127,  0,     256, 1'b1};
    vecs[6]  = '{16'd4000,  8'd3,   16'd3127,  0,     0,   1'b0};
    vecs[7]  = '{16'd5,     8'd3,   16'd1,     0,     0,   1'b0};
    vecs[8]  = '{16'd3126,  8'd2,   16'd3127,  1,     144, 1'b0};
    vecs[9]  = '{16'd65520, 8'd3,   16'd65521, 65520, 160, 1'b0};
    vecs[10] = '{16'd0,     8'd5,   16'd7,     0,     160, 1'b0};
    vecs[11] = '{16'd2,     8'd128, 16'd65521, 0,     144, 1'b1};
    vecs[12] = '{16'd7,     8'd3,   16'd7,     0,     0,   1'b0};
    vecs[13] = '{16'd1,     8'd7,   16'd2,     1,     176, 1'b0};

    rst_n = 1'b1; start = 1'b0; m = '0; e = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_c", c, 0);
    chk("reset_finish", finish, 0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < 14; i++) begin
      int exp_c;
      exp_c = vecs[i].use_model ? int'(modexp(vecs[i].m, vecs[i].e, vecs[i].n)) : vecs[i].exp_c;
      run(vecs[i].m, vecs[i].e, vecs[i].n, exp_c, vecs[i].exp_l, -1, $sformatf("v%0d", i));
    end

    // A start pulse mid-operation must not disturb the running request.
    run(16'd89, 8'd3, 16'd3127, 1394, 160, 40, "ignore_start");

    // Start raised in the finish cycle is accepted on the following edge.
    @(negedge clk);
    start = 1'b1; m = 16'd89; e = 8'd1; n = 16'd3127;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!finish && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_first_lat", cyc, 144);
    chk("b2b_first_c", c, 89);
    start = 1'b1; m = 16'd65; e = 8'd17; n = 16'd3233;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!finish && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("vec b2b c=%0d latency=%0d", c, cyc);
    chk("b2b_second_lat", cyc, 160);
    chk("b2b_second_c", c, 2790);

    // Reset in the middle of an operation aborts it silently.
    @(negedge clk);
    start = 1'b1; m = 16'd2; e = 8'd10; n = 16'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_mid_c", c, 0);
    chk("rst_mid_finish", finish, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (finish) pulses++;
    end
    $display("vec reset_abort pulses=%0d", pulses);
    chk("rst_no_pulse", pulses, 0);
    chk("rst_c_stays", c, 0);
    run(16'd89, 8'd3, 16'd3127, 1394, 160, -1, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_encrypt.md
RSA_ENCRYPT -- requirements
Module: rsa_encrypt

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): MW 16 modulus/message/ciphertext width; EW 8 exponent width.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-high (asserted = 1, despite the name).
REQ-004 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 The block SHALL have port m, input, MW bits: plaintext; captured on the accepting edge.
REQ-006 The block SHALL have port e, input, EW bits: public exponent; captured on the accepting edge.
REQ-007 The block SHALL have port n, input, MW bits: modulus; captured on the accepting edge.
REQ-008 The block SHALL have port c, output, MW bits: ciphertext, registered, held until next accepted start.
REQ-009 The block SHALL have port finish, output, 1 bit: registered one-cycle completion pulse.

Function
REQ-010 The block SHALL compute c = m^e mod n; m, e and n need not be held after the accepting edge.
REQ-011 States SHALL be IDLE, SQR and MUL; start=1 in IDLE SHALL be accepted, and start outside IDLE SHALL be ignored.
REQ-012 On acceptance with n<2 or m>=n, the block SHALL stay in IDLE, set c=0 and pulse finish on the next edge.
REQ-013 Otherwise the accumulator SHALL be set to 1, the bit index to EW-1, and the state to SQR.
REQ-014 Exponentiation SHALL be left-to-right square-and-multiply over all EW bits, leading zeros included.
REQ-015 For each bit, SQR SHALL compute acc=acc*acc mod n.
REQ-016 MUL (acc=acc*m mod n) SHALL execute only when e[bit]=1, so that latency depends on e.
REQ-017 Each modular multiply SHALL be interleaved shift-add, one multiplier bit per cycle MSB-first, taking exactly MW=16 cycles.
REQ-018 Each multiply cycle SHALL compute r=2r; if r>=n then r-=n; if the bit is set r+=a; if r>=n then r-=n.
REQ-019 Multiply intermediates SHALL be MW+2 bits wide, with no overflow for n < 2^MW.
REQ-020 Latency SHALL be L = 16*(EW+w) edges after the accepting edge, where w = popcount(e).
REQ-021 The edge completing the last operation SHALL load c, set finish=1 for one cycle, and return to IDLE.
REQ-022 A start asserted while finish=1 SHALL be accepted, since the block is already in IDLE.
REQ-023 Special cases: e=0 gives c=1 with L=128; e=1 gives c=m with L=144.

Reset
REQ-024 Reset assertion SHALL immediately force state=IDLE, c=0, finish=0, and accumulator, counters and captured operands to 0.
REQ-025 Reset during SQR or MUL SHALL abort the operation with no finish pulse.
REQ-026 The first start after deassertion SHALL be accepted normally.

Structure
REQ-027 Shared package rsa_pkg SHALL hold MW, EW, the state enumeration (IDLE/SQR/MUL) and the constant MODMUL_CYCLES=16.
REQ-028 One sub-module, rsa_modmul, SHALL implement the 16-cycle interleaved modular multiplier (ports: go, a, b, n, done, r).
REQ-029 The top level SHALL contain only the control FSM, operand registers and output registers.

Verification
REQ-030 m=89, e=3, n=3127 SHALL give c=1394 and finish 160 cycles after the accepting edge.
REQ-031 m=65, e=17, n=3233 SHALL give c=2790 with L=160; m=2, e=10, n=1000 SHALL give c=24 with L=160.
REQ-032 m=5, e=0, n=3127 SHALL give c=1 with L=128; m=89, e=1, n=3127 SHALL give c=89 with L=144; e=255 SHALL give L=256 with a result matching the software model.
REQ-033 m=4000, n=3127 (and separately n=1) SHALL give finish on the next edge with c=0.
REQ-034 start pulsed mid-operation SHALL be ignored, with the result and timing of the first request unchanged.
REQ-035 Reset at cycle 50 SHALL clear c/finish and produce no pulse; a subsequent request SHALL complete correctly.
